vga_timing: RTL and testbench
=============================

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter H_ACTIVE, default 800: visible pixels per line.
REQ-003 Parameter H_FP, default 40: horizontal front porch, in pixels.
REQ-004 Parameter H_SYNC, default 128: hsync width, in pixels.
REQ-005 Parameter H_BP, default 88: horizontal back porch, in pixels.
REQ-006 Parameter V_ACTIVE, default 600: visible lines per frame.
REQ-007 Parameter V_FP, default 1: vertical front porch, in lines.
REQ-008 Parameter V_SYNC, default 4: vsync width, in lines.
REQ-009 Parameter V_BP, default 23: vertical back porch, in lines.
REQ-010 pclk  input  1  pixel clock (40 MHz for defaults); all state changes on rising edge.
REQ-011 rst  input  1  synchronous active-high reset.
REQ-012 hcount  output  11  current pixel column, 0..H_TOTAL-1, where H_TOTAL = sum of H_* = 1056.
REQ-013 vcount  output  10  current line, 0..V_TOTAL-1, where V_TOTAL = sum of V_* = 628.
REQ-014 hsync  output  1  active-high horizontal sync.
REQ-015 vsync  output  1  active-high vertical sync; also drives the frame-rate animation clock stage.
REQ-016 hblnk  output  1  high outside the visible columns.
REQ-017 vblnk  output  1  high outside the visible lines.
REQ-018 line_tick  output  1  one-cycle pulse while hcount==0, excluding the reset state.
REQ-019 frame_tick  output  1  one-cycle pulse while hcount==0 and vcount==0, excluding the reset state.

Function
REQ-020 All outputs SHALL be registers; no combinational path from any input to any output.
REQ-021 Every output SHALL describe the same (hcount, vcount) position in the same cycle, with zero skew between counts and flags.
REQ-022 hcount SHALL increment by 1 each cycle and wrap from H_TOTAL-1 to 0.
REQ-023 vcount SHALL increment by 1 only in the cycle hcount wraps; it wraps from V_TOTAL-1 to 0 when hcount also wraps.
REQ-024 hblnk SHALL be high when hcount >= H_ACTIVE.
REQ-025 hsync SHALL be high when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (defaults: 840..967).
REQ-026 vblnk SHALL be high when vcount >= V_ACTIVE.
REQ-027 vsync SHALL be high when V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (defaults: 601..604), for the full width of each of those lines.
REQ-028 Flags SHALL be computed from the next-state counts and registered alongside them, to satisfy REQ-021.
REQ-029 Frame period SHALL be exactly H_TOTAL*V_TOTAL = 663 168 pclk cycles.
REQ-030 vsync SHALL produce exactly one rising edge per frame, with no glitches; downstream frame-counted timing depends on this.
REQ-031 Count arithmetic SHALL be unsigned; wrap comparisons SHALL use == TOTAL-1; counts SHALL never reach H_TOTAL or V_TOTAL.

Reset
REQ-032 While rst is high at a pclk edge: hcount=0, vcount=0, hsync=0, vsync=0, hblnk=0, vblnk=0, line_tick=0, frame_tick=0.
REQ-033 At the first edge with rst low, hcount SHALL become 1 and vcount SHALL stay 0; line_tick and frame_tick SHALL stay 0 until the first wrap.
REQ-034 Reset asserted mid-frame (including during hsync or vsync) SHALL force the REQ-032 values at the next edge, with no partial sync pulse extending past it.

Verification
REQ-035 Release rst, run 2 frames -> hcount follows 1,2,..,1055,0; vcount steps at each hcount wrap; frame_tick first high at cycle 663 168 after release.
REQ-036 Check line 0 -> hblnk rises at hcount=800; hsync high for hcount 840..967 (128 cycles); both low at hcount=0.
REQ-037 Check frame -> vblnk high for vcount 600..627; vsync high for exactly 4*1056 = 4224 consecutive cycles starting at (hcount 0, vcount 601).
REQ-038 Assert rst for 1 cycle at (hcount 900, vcount 602) -> next cycle all outputs 0; vsync rising edge next occurs 601*1056 cycles later.
REQ-039 Over 3 frames -> the vsync rising-edge period is 663 168 cycles; frame_tick count = 3; line_tick count = 3*628.
REQ-040 Instantiate with H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3, V_ACTIVE=8, V_FP=1, V_SYNC=2, V_BP=2 -> hsync at hcount 18..20, vsync at vcount 9..10, frame period 24*13 = 312.

Source files
------------

// File: rtl/vga_timing.sv
// VGA raster timing generator.
// Produces horizontal/vertical pixel counts together with sync, blanking and
// tick flags. Every output is a register, and the flags are derived from the
// next-state counts so that counts and flags always describe the same pixel
// position in the same cycle.
module vga_timing #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23
) (
    input  logic        pclk,
    input  logic        rst,
    output logic [10:0] hcount,
    output logic [9:0]  vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        hblnk,
    output logic        vblnk,
    output logic        line_tick,
    output logic        frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Count-width constants so every comparison is unsigned and width-matched.
    localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_BLANK_FROM = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_FROM  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_UPTO  = 11'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_BLANK_FROM = 10'(V_ACTIVE);
    localparam logic [9:0]  V_SYNC_FROM  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  V_SYNC_UPTO  = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] hcount_next;
    logic [9:0]  vcount_next;
    logic        h_wrap;
    logic        hsync_next;
    logic        vsync_next;
    logic        hblnk_next;
    logic        vblnk_next;
    logic        line_tick_next;
    logic        frame_tick_next;

    // Advance the raster position: column every cycle, line on column wrap.
    always_comb begin
        h_wrap      = (hcount == H_LAST);
        hcount_next = h_wrap ? 11'd0 : hcount + 11'd1;
        vcount_next = vcount;
        if (h_wrap) begin
            vcount_next = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
        end
    end

    // Decode the flags for the position the counters are about to hold.
    always_comb begin
        hblnk_next      = (hcount_next >= H_BLANK_FROM);
        hsync_next      = (hcount_next >= H_SYNC_FROM) && (hcount_next < H_SYNC_UPTO);
        vblnk_next      = (vcount_next >= V_BLANK_FROM);
        vsync_next      = (vcount_next >= V_SYNC_FROM) && (vcount_next < V_SYNC_UPTO);
        line_tick_next  = (hcount_next == 11'd0);
        frame_tick_next = (hcount_next == 11'd0) && (vcount_next == 10'd0);
    end

    // Register counts and flags together; reset parks everything at zero.
    always_ff @(posedge pclk) begin
        if (rst) begin
            hcount     <= 11'd0;
            vcount     <= 10'd0;
            hsync      <= 1'b0;
            vsync      <= 1'b0;
            hblnk      <= 1'b0;
            vblnk      <= 1'b0;
            line_tick  <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            hcount     <= hcount_next;
            vcount     <= vcount_next;
            hsync      <= hsync_next;
            vsync      <= vsync_next;
            hblnk      <= hblnk_next;
            vblnk      <= vblnk_next;
            line_tick  <= line_tick_next;
            frame_tick <= frame_tick_next;
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// Testbench for vga_timing: a default-sized instance and a tiny instance share
// one clock and reset. A position model derived from elapsed cycles predicts
// every output each cycle; directed literal checks pin key raster points.
module tb_vga_timing;

    logic        pclk = 1'b0;
    logic        rst  = 1'b1;

    logic [10:0] d_hcount;
    logic [9:0]  d_vcount;
    logic        d_hsync, d_vsync, d_hblnk, d_vblnk, d_line_tick, d_frame_tick;
    logic [10:0] s_hcount;
    logic [9:0]  s_vcount;
    logic        s_hsync, s_vsync, s_hblnk, s_vblnk, s_line_tick, s_frame_tick;

    logic [26:0] d_vec;
    logic [26:0] s_vec;

    int          checks   = 0;
    int          failures = 0;
    longint      t        = 0;
    bit          cmp_en   = 1'b0;
    bit          phase2   = 1'b0;

    int          s_frame_ticks = 0;
    int          s_line_ticks  = 0;
    int          d_line_ticks  = 0;
    int          d_hsync_cnt   = 0;
    logic        s_prev_vsync  = 1'b0;
    longint      rise_first    = -1;
    longint      rise_second   = -1;

    vga_timing dut_def (
        .pclk       (pclk),
        .rst        (rst),
        .hcount     (d_hcount),
        .vcount     (d_vcount),
        .hsync      (d_hsync),
        .vsync      (d_vsync),
        .hblnk      (d_hblnk),
        .vblnk      (d_vblnk),
        .line_tick  (d_line_tick),
        .frame_tick (d_frame_tick)
    );

    vga_timing #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) dut_small (
        .pclk       (pclk),
        .rst        (rst),
        .hcount     (s_hcount),
        .vcount     (s_vcount),
        .hsync      (s_hsync),
        .vsync      (s_vsync),
        .hblnk      (s_hblnk),
        .vblnk      (s_vblnk),
        .line_tick  (s_line_tick),
        .frame_tick (s_frame_tick)
    );

    assign d_vec = {d_hcount, d_vcount, d_hsync, d_vsync, d_hblnk, d_vblnk, d_line_tick, d_frame_tick};
    assign s_vec = {s_hcount, s_vcount, s_hsync, s_vsync, s_hblnk, s_vblnk, s_line_tick, s_frame_tick};

    // Free-running pixel clock.
    always #5 pclk = ~pclk;

    // Expected outputs after tt clock edges since the last reset edge
    // (tt = 0 is the reset state itself).
    function automatic logic [26:0] model(input longint tt,
                                          input longint ha, input longint hf,
                                          input longint hs, input longint hb,
                                          input longint va, input longint vf,
                                          input longint vs, input longint vb);
        longint ht, vt, h, v;
        logic   hsy, vsy, hbl, vbl, lt, ft;
        ht  = ha + hf + hs + hb;
        vt  = va + vf + vs + vb;
        h   = tt % ht;
        v   = (tt / ht) % vt;
        hbl = (h >= ha);
        hsy = (h >= ha + hf) && (h < ha + hf + hs);
        vbl = (v >= va);
        vsy = (v >= va + vf) && (v < va + vf + vs);
        lt  = (tt > 0) && (h == 0);
        ft  = (tt > 0) && ((tt % (ht * vt)) == 0);
        return {h[10:0], v[9:0], hsy, vsy, hbl, vbl, lt, ft};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s t=%0d got=0x%0h expected=0x%0h", name, t, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst_value, input int cycles);
        rst = rst_value;
        repeat (cycles) @(negedge pclk);
    endtask

    task automatic stepTo(input longint target);
        int budget;
        budget = 5000;
        while (t != target && budget > 0) begin
            @(negedge pclk);
            budget--;
        end
        if (budget == 0) checkOutput("step_timeout", 32'(t), 32'(target));
    endtask

    // Track elapsed edges since reset and compare both instances every cycle.
    always begin
        @(posedge pclk);
        if (rst) t = 0;
        else     t = t + 1;
        #1;
        if (cmp_en) begin
            checkOutput("cycle_def",   32'(d_vec), 32'(model(t, 800, 40, 128, 88, 600, 1, 4, 23)));
            checkOutput("cycle_small", 32'(s_vec), 32'(model(t, 16, 2, 3, 3, 8, 1, 2, 2)));
            if (phase2) begin
                if (t >= 1 && t <= 936) begin
                    if (s_frame_tick) s_frame_ticks++;
                    if (s_line_tick)  s_line_ticks++;
                end
                if (t >= 1 && t <= 2112 && d_line_tick) d_line_ticks++;
                if (t >= 1 && t <= 1055 && d_hsync) d_hsync_cnt++;
                if (s_vsync && !s_prev_vsync) begin
                    if (rise_first < 0)       rise_first  = t;
                    else if (rise_second < 0) rise_second = t;
                end
                s_prev_vsync = s_vsync;
            end
        end
    end

    // Directed sequence: reset, mid-vsync reset on the small raster, then
    // literal checks at known positions and aggregate counts.
    initial begin
        applyStimulus(1'b1, 3);
        cmp_en = 1'b1;
        checkOutput("reset_def",   32'(d_vec), 32'd0);
        checkOutput("reset_small", 32'(s_vec), 32'd0);

        rst = 1'b0;
        stepTo(259);
        checkOutput("pre_rst_s_vcount", 32'(s_vcount), 32'd10);
        checkOutput("pre_rst_s_hcount", 32'(s_hcount), 32'd19);
        checkOutput("pre_rst_s_vsync",  32'(s_vsync),  32'd1);
        checkOutput("pre_rst_s_hsync",  32'(s_hsync),  32'd1);

        applyStimulus(1'b1, 1);
        checkOutput("midrst_small", 32'(s_vec), 32'd0);
        checkOutput("midrst_def",   32'(d_vec), 32'd0);
        phase2 = 1'b1;
        rst = 1'b0;

        stepTo(1);
        checkOutput("first_hcount", 32'(d_hcount),    32'd1);
        checkOutput("first_vcount", 32'(d_vcount),    32'd0);
        checkOutput("first_ltick",  32'(d_line_tick), 32'd0);
        stepTo(18);
        checkOutput("s_hsync_18",   32'(s_hsync), 32'd1);
        checkOutput("s_hblnk_18",   32'(s_hblnk), 32'd1);
        stepTo(20);
        checkOutput("s_hsync_20",   32'(s_hsync), 32'd1);
        stepTo(21);
        checkOutput("s_hsync_21",   32'(s_hsync), 32'd0);
        stepTo(24);
        checkOutput("s_wrap_h",     32'(s_hcount),     32'd0);
        checkOutput("s_wrap_v",     32'(s_vcount),     32'd1);
        checkOutput("s_wrap_lt",    32'(s_line_tick),  32'd1);
        checkOutput("s_wrap_ft",    32'(s_frame_tick), 32'd0);
        stepTo(215);
        checkOutput("s_vsync_215",  32'(s_vsync), 32'd0);
        stepTo(216);
        checkOutput("s_vsync_216",  32'(s_vsync),  32'd1);
        checkOutput("s_vcount_216", 32'(s_vcount), 32'd9);
        stepTo(263);
        checkOutput("s_vsync_263",  32'(s_vsync), 32'd1);
        stepTo(264);
        checkOutput("s_vsync_264",  32'(s_vsync), 32'd0);
        stepTo(312);
        checkOutput("s_ftick_312",  32'(s_frame_tick), 32'd1);
        checkOutput("s_vcount_312", 32'(s_vcount),     32'd0);
        stepTo(799);
        checkOutput("d_hblnk_799",  32'(d_hblnk), 32'd0);
        stepTo(800);
        checkOutput("d_hblnk_800",  32'(d_hblnk), 32'd1);
        stepTo(839);
        checkOutput("d_hsync_839",  32'(d_hsync), 32'd0);
        stepTo(840);
        checkOutput("d_hsync_840",  32'(d_hsync), 32'd1);
        stepTo(967);
        checkOutput("d_hsync_967",  32'(d_hsync), 32'd1);
        stepTo(968);
        checkOutput("d_hsync_968",  32'(d_hsync), 32'd0);
        stepTo(1056);
        checkOutput("d_wrap_h",     32'(d_hcount),    32'd0);
        checkOutput("d_wrap_v",     32'(d_vcount),    32'd1);
        checkOutput("d_wrap_hsync", 32'(d_hsync),     32'd0);
        checkOutput("d_wrap_hblnk", 32'(d_hblnk),     32'd0);
        checkOutput("d_wrap_lt",    32'(d_line_tick), 32'd1);

        stepTo(2200);
        checkOutput("s_frame_ticks", 32'(s_frame_ticks), 32'd3);
        checkOutput("s_line_ticks",  32'(s_line_ticks),  32'd39);
        checkOutput("d_line_ticks",  32'(d_line_ticks),  32'd2);
        checkOutput("d_hsync_width", 32'(d_hsync_cnt),   32'd128);
        checkOutput("s_vsync_first", 32'(rise_first),    32'd216);
        checkOutput("s_vsync_period", 32'(rise_second - rise_first), 32'd312);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
